// File: rtl/wav_pkg.sv
// rtl/wav_pkg.sv - shared types and constants for the WAV stream parser
package wav_pkg;

  typedef enum logic [2:0] {
    ST_RIFF,
    ST_CHK_HDR,
    ST_FMT,
    ST_SKIP,
    ST_DATA,
    ST_DONE,
    ST_ERR
  } wav_state_t;

  localparam logic [2:0] ERR_OK       = 3'd0;
  localparam logic [2:0] ERR_RIFF     = 3'd1;
  localparam logic [2:0] ERR_FMT      = 3'd2;
  localparam logic [2:0] ERR_ORDER    = 3'd3;
  localparam logic [2:0] ERR_HDR_LONG = 3'd4;

  // Chunk IDs as they appear after little-endian capture of four ASCII bytes
  localparam logic [31:0] ID_RIFF = 32'h46464952;
  localparam logic [31:0] ID_WAVE = 32'h45564157;
  localparam logic [31:0] ID_FMT  = 32'h20746D66;
  localparam logic [31:0] ID_DATA = 32'h61746164;

  localparam int FRAME_W = 32;

endpackage

// File: rtl/wav_stream_parser_if.sv
// rtl/wav_stream_parser_if.sv - byte input and frame output handshakes of the parser
interface wav_stream_parser_if;
  import wav_pkg::*;

  logic [7:0]         in_data;
  logic               in_valid;
  logic               in_ready;
  logic [FRAME_W-1:0] out_data;
  logic               out_valid;
  logic               out_ready;
  logic               out_last;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );

endinterface

// File: rtl/wav_frame_packer.sv
// rtl/wav_frame_packer.sv - assembles data bytes into {L,R} frames behind one output register
module wav_frame_packer
  import wav_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clear,
  input  logic [15:0]        i_num_channels,
  input  logic               i_strobe,
  input  logic [7:0]         i_byte,
  input  logic               i_last,
  input  logic               i_out_ready,
  output logic               o_frame_end,
  output logic [FRAME_W-1:0] o_data,
  output logic               o_valid,
  output logic               o_last
);

  logic               w_stereo;
  logic [1:0]         r_lane;
  logic [7:0]         r_b0;
  logic [7:0]         r_b1;
  logic [7:0]         r_b2;
  logic [FRAME_W-1:0] r_data;
  logic               r_valid;
  logic               r_last;

  assign w_stereo    = (i_num_channels == 16'd2);
  assign o_frame_end = i_strobe && (r_lane == (w_stereo ? 2'd3 : 2'd1));
  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_last      = r_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lane  <= 2'd0;
      r_b0    <= 8'd0;
      r_b1    <= 8'd0;
      r_b2    <= 8'd0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (i_clear) begin
      r_lane  <= 2'd0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      if (o_frame_end) begin
        r_data  <= w_stereo ? {r_b1, r_b0, i_byte, r_b2} : {i_byte, r_b0, i_byte, r_b0};
        r_valid <= 1'b1;
        r_last  <= i_last;
      end else if (i_out_ready) begin
        r_valid <= 1'b0;
      end
      if (i_strobe) begin
        // A final byte that does not finish a frame drops the partial lanes
        r_lane <= (o_frame_end || i_last) ? 2'd0 : r_lane + 2'd1;
        case (r_lane)
          2'd0:    r_b0 <= i_byte;
          2'd1:    r_b1 <= i_byte;
          2'd2:    r_b2 <= i_byte;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/wav_stream_parser.sv
// rtl/wav_stream_parser.sv - RIFF/WAVE header parser feeding the frame packer
module wav_stream_parser #(
  parameter int MAX_HDR_BYTES = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  wav_stream_parser_if.slave      s_if,
  output logic                    o_hdr_valid,
  output logic [31:0]             o_sample_rate,
  output logic [15:0]             o_num_channels,
  output logic [15:0]             o_bits_per_sample,
  output logic [31:0]             o_data_len,
  output logic                    o_done,
  output logic [2:0]              o_error
);
  import wav_pkg::*;

  localparam logic [31:0] HDR_LIMIT = 32'(MAX_HDR_BYTES);

  wav_state_t  r_state;
  logic [31:0] r_sh;
  logic [3:0]  r_cnt;
  logic [31:0] r_hdr_cnt;
  logic [31:0] r_id;
  logic [31:0] r_chunk_size;
  logic [32:0] r_skip_left;
  logic [31:0] r_remaining;
  logic        r_fmt_seen;
  logic [15:0] r_format;
  logic [15:0] r_num_channels;
  logic [31:0] r_sample_rate;
  logic [15:0] r_bits;
  logic [31:0] r_data_len;
  logic        r_hdr_valid;
  logic        r_done;
  logic [2:0]  r_error;

  logic [31:0] w_sh_next;
  logic [32:0] w_fmt_extra;
  logic        w_hdr_state;
  logic        w_accept;
  logic        w_data_strobe;
  logic        w_last_byte;
  logic        w_frame_end;
  logic        w_pk_valid;
  logic        w_pk_last;
  logic        w_final_hs;
  logic        w_over_budget;

  assign w_hdr_state   = (r_state == ST_RIFF) || (r_state == ST_CHK_HDR) ||
                         (r_state == ST_FMT)  || (r_state == ST_SKIP);
  assign s_if.in_ready = !rst && !i_start &&
                         (w_hdr_state || ((r_state == ST_DATA) && (r_remaining != 32'd0) &&
                                          (!w_pk_valid || s_if.out_ready)));
  assign w_accept      = s_if.in_valid && s_if.in_ready;
  assign w_sh_next     = {s_if.in_data, r_sh[31:8]};
  assign w_data_strobe = w_accept && (r_state == ST_DATA);
  assign w_last_byte   = (r_remaining == 32'd1);
  assign w_final_hs    = w_pk_valid && s_if.out_ready && w_pk_last;
  assign w_over_budget = (r_hdr_cnt >= HDR_LIMIT);
  // fmt bytes past the 16 we parse, including the odd-size pad byte
  assign w_fmt_extra   = {1'b0, r_chunk_size} - 33'd16 + {32'd0, r_chunk_size[0]};

  assign s_if.out_valid   = w_pk_valid;
  assign s_if.out_last    = w_pk_last;
  assign o_hdr_valid       = r_hdr_valid;
  assign o_sample_rate     = r_sample_rate;
  assign o_num_channels    = r_num_channels;
  assign o_bits_per_sample = r_bits;
  assign o_data_len        = r_data_len;
  assign o_done            = r_done;
  assign o_error           = r_error;

  wav_frame_packer u_packer (
    .clk            (clk),
    .rst            (rst),
    .i_clear        (i_start),
    .i_num_channels (r_num_channels),
    .i_strobe       (w_data_strobe),
    .i_byte         (s_if.in_data),
    .i_last         (w_last_byte),
    .i_out_ready    (s_if.out_ready),
    .o_frame_end    (w_frame_end),
    .o_data         (s_if.out_data),
    .o_valid        (w_pk_valid),
    .o_last         (w_pk_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_RIFF;
      r_sh           <= '0;
      r_cnt          <= '0;
      r_hdr_cnt      <= '0;
      r_id           <= '0;
      r_chunk_size   <= '0;
      r_skip_left    <= '0;
      r_remaining    <= '0;
      r_fmt_seen     <= 1'b0;
      r_format       <= '0;
      r_num_channels <= '0;
      r_sample_rate  <= '0;
      r_bits         <= '0;
      r_data_len     <= '0;
      r_hdr_valid    <= 1'b0;
      r_done         <= 1'b0;
      r_error        <= ERR_OK;
    end else if (i_start) begin
      r_state     <= ST_RIFF;
      r_sh        <= '0;
      r_cnt       <= '0;
      r_hdr_cnt   <= '0;
      r_skip_left <= '0;
      r_remaining <= '0;
      r_fmt_seen  <= 1'b0;
      r_hdr_valid <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= ERR_OK;
    end else begin
      if (w_accept) r_sh <= w_sh_next;
      if (w_accept && w_hdr_state) r_hdr_cnt <= r_hdr_cnt + 32'd1;

      if (w_accept && w_hdr_state && w_over_budget) begin
        r_state <= ST_ERR;
        r_error <= ERR_HDR_LONG;
      end else begin
        case (r_state)
          ST_RIFF: if (w_accept) begin
            r_cnt <= r_cnt + 4'd1;
            if (((r_cnt == 4'd3) && (w_sh_next != ID_RIFF)) ||
                ((r_cnt == 4'd11) && (w_sh_next != ID_WAVE))) begin
              r_state <= ST_ERR;
              r_error <= ERR_RIFF;
            end else if (r_cnt == 4'd11) begin
              r_state <= ST_CHK_HDR;
              r_cnt   <= 4'd0;
            end
          end

          ST_CHK_HDR: if (w_accept) begin
            r_cnt <= r_cnt + 4'd1;
            if (r_cnt == 4'd3) r_id <= w_sh_next;
            if (r_cnt == 4'd7) begin
              r_cnt        <= 4'd0;
              r_chunk_size <= w_sh_next;
              if (r_id == ID_FMT) begin
                r_state <= ST_FMT;
              end else if (r_id == ID_DATA) begin
                if (!r_fmt_seen) begin
                  r_state <= ST_ERR;
                  r_error <= ERR_ORDER;
                end else begin
                  r_data_len  <= w_sh_next;
                  r_remaining <= w_sh_next;
                  r_hdr_valid <= 1'b1;
                  if (w_sh_next == 32'd0) begin
                    r_state <= ST_DONE;
                    r_done  <= 1'b1;
                  end else begin
                    r_state <= ST_DATA;
                  end
                end
              end else if (w_sh_next != 32'd0) begin
                r_skip_left <= {1'b0, w_sh_next} + {32'd0, w_sh_next[0]};
                r_state     <= ST_SKIP;
              end
            end
          end

          ST_FMT: if (w_accept) begin
            r_cnt <= r_cnt + 4'd1;
            if (r_cnt == 4'd1) r_format <= w_sh_next[31:16];
            if (r_cnt == 4'd3) r_num_channels <= w_sh_next[31:16];
            if (r_cnt == 4'd7) r_sample_rate <= w_sh_next;
            if (r_cnt == 4'd15) begin
              r_bits <= w_sh_next[31:16];
              if ((r_format != 16'd1) || (w_sh_next[31:16] != 16'd16) ||
                  ((r_num_channels != 16'd1) && (r_num_channels != 16'd2)) ||
                  (r_chunk_size < 32'd16)) begin
                r_state <= ST_ERR;
                r_error <= ERR_FMT;
              end else begin
                r_fmt_seen <= 1'b1;
                r_cnt      <= 4'd0;
                if (w_fmt_extra == 33'd0) begin
                  r_state <= ST_CHK_HDR;
                end else begin
                  r_skip_left <= w_fmt_extra;
                  r_state     <= ST_SKIP;
                end
              end
            end
          end

          ST_SKIP: if (w_accept) begin
            r_skip_left <= r_skip_left - 33'd1;
            if (r_skip_left == 33'd1) begin
              r_state <= ST_CHK_HDR;
              r_cnt   <= 4'd0;
            end
          end

          ST_DATA: begin
            if (w_accept) r_remaining <= r_remaining - 32'd1;
            // Finish on the last frame handshake, or at once if the last byte was dropped
            if (w_final_hs || (w_accept && w_last_byte && !w_frame_end)) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end

          ST_DONE, ST_ERR: ;

          default: r_state <= ST_ERR;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wav_stream_parser.sv
// tb/tb_wav_stream_parser.sv - directed self-checking bench for wav_stream_parser
module tb_wav_stream_parser;

  logic        clk;
  logic        rst;
  logic        start;
  logic        hdr_valid;
  logic [31:0] sample_rate;
  logic [15:0] num_channels;
  logic [15:0] bits_per_sample;
  logic [31:0] data_len;
  logic        done;
  logic [2:0]  error;

  wav_stream_parser_if bus();

  wav_stream_parser #(.MAX_HDR_BYTES(4096)) dut (
    .clk               (clk),
    .rst               (rst),
    .i_start           (start),
    .s_if              (bus),
    .o_hdr_valid       (hdr_valid),
    .o_sample_rate     (sample_rate),
    .o_num_channels    (num_channels),
    .o_bits_per_sample (bits_per_sample),
    .o_data_len        (data_len),
    .o_done            (done),
    .o_error           (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [7:0]  fq[$];
  logic [31:0] got_data[$];
  logic        got_last[$];
  int          idx;
  int          stall_seen;
  int          stall_bad;

  task automatic push16(input logic [15:0] v);
    fq.push_back(v[7:0]);
    fq.push_back(v[15:8]);
  endtask

  task automatic push32(input logic [31:0] v);
    push16(v[15:0]);
    push16(v[31:16]);
  endtask

  task automatic push_riff(input logic [31:0] id);
    push32(id);
    push32(32'd36);
    push32(32'h45564157);
  endtask

  task automatic push_fmt(input logic [15:0] ch, input logic [15:0] bits);
    push32(32'h20746D66);
    push32(32'd16);
    push16(16'd1);
    push16(ch);
    push32(32'd48000);
    push32(32'd192000);
    push16(16'd4);
    push16(bits);
  endtask

  task automatic min_file(input logic [31:0] dlen);
    fq.delete();
    push_riff(32'h46464952);
    push_fmt(16'd2, 16'd16);
    push32(32'h61746164);
    push32(dlen);
    push16(16'd1); push16(16'd2); push16(16'd3); push16(16'd4);
  endtask

  function automatic logic [31:0] frame(input int i);
    if (i < got_data.size()) return got_data[i];
    return 32'hDEADBEEF;
  endfunction

  function automatic logic lastf(input int i);
    if (i < got_last.size()) return got_last[i];
    return 1'b0;
  endfunction

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Streams fq until done/error, max_bytes consumed, or the cycle budget expires
  task automatic run(input int max_cycles, input int bp, input int max_bytes);
    int          cyc = 0;
    int          bp_left = bp;
    logic [31:0] held = '0;
    bit          have_held = 1'b0;
    got_data.delete();
    got_last.delete();
    idx = 0;
    stall_seen = 0;
    stall_bad = 0;
    forever begin
      @(negedge clk);
      if (done || error != 3'd0 || idx >= max_bytes) break;
      if (cyc >= max_cycles) begin
        $display("FAIL run_timeout: %0d bytes after %0d cycles, required done or error", idx, cyc);
        n_vec++;
        n_bad++;
        break;
      end
      cyc++;
      if (idx < fq.size()) begin
        bus.in_valid = 1'b1;
        bus.in_data  = fq[idx];
      end else begin
        bus.in_valid = 1'b0;
      end
      bus.out_ready = (bp_left == 0);
      #1;
      if (bus.out_valid && !bus.out_ready) begin
        stall_seen++;
        if (!have_held) begin
          held = bus.out_data;
          have_held = 1'b1;
        end else if (bus.out_data !== held) begin
          stall_bad++;
        end
        if (bus.in_ready) stall_bad++;
        bp_left--;
      end
      if (bus.in_valid && bus.in_ready) idx++;
      if (bus.out_valid && bus.out_ready) begin
        got_data.push_back(bus.out_data);
        got_last.push_back(bus.out_last);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    n_vec++; if (bus.in_ready !== 1'b0) begin $display("FAIL rst_in_ready_held: got %b want 0", bus.in_ready); n_bad++; end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++; if (bus.in_ready !== 1'b1) begin $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); n_bad++; end
    n_vec++; if ({bus.out_valid, hdr_valid, done, error} !== 6'd0) begin $display("FAIL rst_flags: got %b want 0", {bus.out_valid, hdr_valid, done, error}); n_bad++; end
    n_vec++; if (sample_rate !== 32'd0) begin $display("FAIL rst_rate: got %0d want 0", sample_rate); n_bad++; end
  endtask

  task automatic test_minimal();
    do_start();
    min_file(32'd8);
    run(400, 0, 1 << 30);
    n_vec++; if (got_data.size() !== 2) begin $display("FAIL min_count: got %0d want 2", got_data.size()); n_bad++; end
    n_vec++; if (frame(0) !== 32'h00010002 || lastf(0) !== 1'b0) begin $display("FAIL min_frame0: got %h/%b want 00010002/0", frame(0), lastf(0)); n_bad++; end
    n_vec++; if (frame(1) !== 32'h00030004 || lastf(1) !== 1'b1) begin $display("FAIL min_frame1: got %h/%b want 00030004/1", frame(1), lastf(1)); n_bad++; end
    n_vec++; if (done !== 1'b1 || hdr_valid !== 1'b1) begin $display("FAIL min_done: got %b%b want 11", done, hdr_valid); n_bad++; end
    n_vec++; if (sample_rate !== 32'd48000 || num_channels !== 16'd2 || bits_per_sample !== 16'd16 || data_len !== 32'd8)
      begin $display("FAIL min_fields: got %0d/%0d/%0d/%0d want 48000/2/16/8", sample_rate, num_channels, bits_per_sample, data_len); n_bad++; end
    #1;
    n_vec++; if (bus.in_ready !== 1'b0) begin $display("FAIL min_in_ready_done: got %b want 0", bus.in_ready); n_bad++; end
  endtask

  task automatic test_list_skip();
    do_start();
    fq.delete();
    push_riff(32'h46464952);
    push_fmt(16'd2, 16'd16);
    push32(32'h5453494C);
    push32(32'd27);
    for (int i = 0; i < 28; i++) fq.push_back(8'hEE);
    push32(32'h61746164);
    push32(32'd8);
    push16(16'd1); push16(16'd2); push16(16'd3); push16(16'd4);
    run(400, 0, 1 << 30);
    n_vec++; if (got_data.size() !== 2 || frame(0) !== 32'h00010002 || frame(1) !== 32'h00030004 || lastf(1) !== 1'b1)
      begin $display("FAIL list_frames: got %0d %h %h want 2 00010002 00030004", got_data.size(), frame(0), frame(1)); n_bad++; end
    n_vec++; if (done !== 1'b1 || idx !== 88) begin $display("FAIL list_bytes: got done=%b bytes=%0d want 1 88", done, idx); n_bad++; end
  endtask

  task automatic test_mono();
    do_start();
    fq.delete();
    push_riff(32'h46464952);
    push_fmt(16'd1, 16'd16);
    push32(32'h61746164);
    push32(32'd2);
    push16(16'h1234);
    run(400, 0, 1 << 30);
    n_vec++; if (got_data.size() !== 1 || frame(0) !== 32'h12341234 || lastf(0) !== 1'b1)
      begin $display("FAIL mono_frame: got %0d %h/%b want 1 12341234/1", got_data.size(), frame(0), lastf(0)); n_bad++; end
    n_vec++; if (num_channels !== 16'd1 || done !== 1'b1) begin $display("FAIL mono_fields: got ch=%0d done=%b want 1 1", num_channels, done); n_bad++; end
  endtask

  task automatic test_partial();
    do_start();
    min_file(32'd6);
    run(400, 0, 1 << 30);
    n_vec++; if (got_data.size() !== 1 || frame(0) !== 32'h00010002 || lastf(0) !== 1'b0)
      begin $display("FAIL part_frame: got %0d %h/%b want 1 00010002/0", got_data.size(), frame(0), lastf(0)); n_bad++; end
    n_vec++; if (done !== 1'b1 || idx !== 50) begin $display("FAIL part_done: got done=%b bytes=%0d want 1 50", done, idx); n_bad++; end
  endtask

  task automatic test_errors();
    do_start();
    fq.delete();
    push_riff(32'h58464952);
    push_fmt(16'd2, 16'd16);
    run(400, 0, 1 << 30);
    #1;
    n_vec++; if (error !== 3'd1 || idx !== 4 || bus.in_ready !== 1'b0) begin $display("FAIL err_riff: got %0d bytes=%0d rdy=%b want 1 4 0", error, idx, bus.in_ready); n_bad++; end

    do_start();
    fq.delete();
    push_riff(32'h46464952);
    push_fmt(16'd2, 16'd8);
    run(400, 0, 1 << 30);
    #1;
    n_vec++; if (error !== 3'd2 || idx !== 36 || bus.in_ready !== 1'b0) begin $display("FAIL err_fmt: got %0d bytes=%0d rdy=%b want 2 36 0", error, idx, bus.in_ready); n_bad++; end

    do_start();
    fq.delete();
    push_riff(32'h46464952);
    push32(32'h61746164);
    push32(32'd8);
    push_fmt(16'd2, 16'd16);
    run(400, 0, 1 << 30);
    #1;
    n_vec++; if (error !== 3'd3 || idx !== 20 || bus.in_ready !== 1'b0) begin $display("FAIL err_order: got %0d bytes=%0d rdy=%b want 3 20 0", error, idx, bus.in_ready); n_bad++; end

    do_start();
    fq.delete();
    push_riff(32'h46464952);
    push_fmt(16'd2, 16'd16);
    push32(32'h5453494C);
    push32(32'd8000);
    for (int i = 0; i < 4200; i++) fq.push_back(8'h00);
    run(6000, 0, 1 << 30);
    #1;
    n_vec++; if (error !== 3'd4 || idx !== 4097 || bus.in_ready !== 1'b0) begin $display("FAIL err_budget: got %0d bytes=%0d rdy=%b want 4 4097 0", error, idx, bus.in_ready); n_bad++; end
  endtask

  task automatic test_backpressure();
    do_start();
    min_file(32'd8);
    run(400, 10, 1 << 30);
    n_vec++; if (stall_seen !== 10 || stall_bad !== 0) begin $display("FAIL bp_hold: got stalls=%0d bad=%0d want 10 0", stall_seen, stall_bad); n_bad++; end
    n_vec++; if (got_data.size() !== 2 || frame(0) !== 32'h00010002 || frame(1) !== 32'h00030004 || done !== 1'b1)
      begin $display("FAIL bp_frames: got %0d %h %h done=%b want 2 00010002 00030004 1", got_data.size(), frame(0), frame(1), done); n_bad++; end
  endtask

  task automatic test_start_mid();
    do_start();
    min_file(32'd8);
    run(400, 0, 46);
    @(negedge clk);
    start = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 8'hAA;
    #1;
    n_vec++; if (bus.in_ready !== 1'b0) begin $display("FAIL start_in_ready: got %b want 0", bus.in_ready); n_bad++; end
    @(negedge clk);
    start = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    n_vec++; if ({hdr_valid, bus.out_valid, done, error} !== 6'd0) begin $display("FAIL start_clear: got %b want 0", {hdr_valid, bus.out_valid, done, error}); n_bad++; end
    min_file(32'd8);
    run(400, 0, 1 << 30);
    n_vec++; if (got_data.size() !== 2 || frame(0) !== 32'h00010002 || frame(1) !== 32'h00030004 || lastf(1) !== 1'b1)
      begin $display("FAIL start_reparse: got %0d %h %h want 2 00010002 00030004", got_data.size(), frame(0), frame(1)); n_bad++; end
  endtask

  task automatic test_rst_mid();
    do_start();
    min_file(32'd8);
    run(400, 0, 47);
    n_vec++; if (hdr_valid !== 1'b1) begin $display("FAIL rstmid_pre: got hdr_valid=%b want 1", hdr_valid); n_bad++; end
    rst = 1'b1;
    #1;
    n_vec++; if ({hdr_valid, bus.in_ready, bus.out_valid, done, error} !== 7'd0 || sample_rate !== 32'd0 || data_len !== 32'd0)
      begin $display("FAIL rstmid_async: got %b rate=%0d len=%0d want 0 0 0", {hdr_valid, bus.in_ready, bus.out_valid, done, error}, sample_rate, data_len); n_bad++; end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    bus.out_ready = 1'b1;
    test_reset();
    test_minimal();
    test_list_skip();
    test_mono();
    test_partial();
    test_errors();
    test_backpressure();
    test_start_mid();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
